fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Parametrised instruction-fetch engine between the Sysbus and the decode stage. Issues line-sized burst reads, splits each bus beat into instruction words, and buffers them with their PCs in an internal FIFO for decode to consume through a valid/ready handshake. Supports redirect (flush and refetch from a new PC) and halts on an all-zero instruction. Replaces the fixed 64-bit, 2-instruction-per-beat fetch sequencing in the top level.

## Interface
- BUS_DATA_WIDTH, 64, bus beat width; a multiple of INSTR_WIDTH.
- BUS_TAG_WIDTH, 13, Sysbus tag width.
- INSTR_WIDTH, 32, instruction word width.
- BURST_BEATS, 8, beats per line read.
- FIFO_DEPTH, 16, instruction entries; a power of two, and at least BURST_BEATS*IPB.
- Derived: IPB = BUS_DATA_WIDTH/INSTR_WIDTH; LINE_BYTES = BURST_BEATS*BUS_DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry  in  64  program entry PC, sampled in INIT.
- bus_reqcyc  out  1  request valid.
- bus_reqack  in  1  request accepted.
- bus_req  out  BUS_DATA_WIDTH  line-aligned read address.
- bus_reqtag  out  BUS_TAG_WIDTH  {1'b1, `SYSBUS_MEMORY, 8'b0}.
- bus_respcyc  in  1  response beat valid.
- bus_respack  out  1  beat consumed, combinational, same cycle as bus_respcyc.
- bus_resp  in  BUS_DATA_WIDTH  response data.
- bus_resptag  in  BUS_TAG_WIDTH  ignored; one burst outstanding at a time.
- redirect_valid  in  1  flush and refetch.
- redirect_pc  in  64  new PC; INSTR_WIDTH/8-aligned.
- instr_valid  out  1  FIFO head is valid.
- instr  out  INSTR_WIDTH  head instruction.
- instr_pc  out  64  head PC.
- instr_ready  in  1  decode pops when valid and ready are both high.
- halt  out  1  sticky flag: a zero instruction was fetched.

## Operation
- States:
  - INIT: load fetch_pc <= entry, then go to WAIT_SPACE.
  - WAIT_SPACE: go to REQ when free entries >= BURST_BEATS*IPB and halt is low.
  - REQ: assert bus_reqcyc with address and tag held stable; go to RESP on bus_reqack.
  - RESP: accept beats and count them. After the BURST_BEATS-th beat, set fetch_pc <= line base + LINE_BYTES and return to WAIT_SPACE.
  - DISCARD: acknowledge and drop the remaining beats of the burst, then go to WAIT_SPACE.
- Beat split: instruction k (0 = least significant bits) has PC = line base + beat*BUS_DATA_WIDTH/8 + k*INSTR_WIDTH/8.
  - Instructions with PC < skip_pc are dropped. skip_pc is set by a redirect and applies only to the first line after it.
  - All kept instructions of a beat are pushed in one cycle. The FIFO never overflows, because space was reserved before the request.
- Zero instruction: the word is not pushed, and later words in the same beat are dropped. halt is set, the rest of the burst is handled as DISCARD, and no further requests are issued.
- Redirect (any state except INIT):
  - The FIFO is flushed in that cycle and any simultaneous pop is ignored.
  - halt is cleared.
  - fetch_pc <= redirect_pc aligned down to LINE_BYTES, and skip_pc <= redirect_pc.
  - In WAIT_SPACE: stay in WAIT_SPACE.
  - In REQ: the request stays asserted until ack, then the burst is discarded.
  - In RESP: go to DISCARD. A beat accepted in the same cycle is acknowledged but not pushed.
- A simultaneous push and pop on the FIFO is legal; occupancy changes by pushes minus pops.

## Timing
- Reset values: all bus outputs 0, instr_valid 0, instr 0, instr_pc 0, halt 0, state INIT, FIFO empty.
- First bus_reqcyc is asserted 2 cycles after reset deassertion (INIT, then WAIT_SPACE, then REQ).
- A beat accepted at edge t makes its first instruction visible on instr_valid after edge t, i.e. 1 cycle of latency.
- A redirect at edge t drives instr_valid low from t+1.
- instr and instr_pc are stable while instr_valid is high and instr_ready is low.

## Structure
- fetch_pkg holds the state enum (INIT, WAIT_SPACE, REQ, RESP, DISCARD) and the read-tag constant built from Sysbus.defs.
- Derived widths (IPB, LINE_BYTES, counter widths via $clog2) are module localparams.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} entries with a multi-entry push (up to IPB per cycle), single pop, flush, and a free-count output.

## Test plan
- Reset release with entry=0x1000 and reqack high after 1 cycle -> bus_req=0x1000, tag 0x1100. The 8 beats 0x00000002_00000001, and so on, produce 16 instructions with PCs 0x1000, 0x1004, … 0x103C, in order.
- instr_ready held low -> the first burst fills 16 entries. No second bus_reqcyc until 16 pops have occurred; the second request is to 0x1040.
- Beat 3 contains 0x00000000_00000013 -> 0x13 is pushed, halt rises, beats 4-7 are acknowledged but not pushed, and no new request is issued.
- redirect_pc=0x2008 during RESP beat 5 -> FIFO empties next cycle, remaining beats are discarded, the next request is to 0x2000, and the first instr_pc is 0x2008.
- Redirect in the same cycle as a pop with instr_valid high -> the popped entry is lost with the flush, and FIFO occupancy is 0.
- Reset asserted in RESP mid-burst -> all outputs go to 0 immediately; after release the engine refetches from entry.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch engine: FSM state codes and the
// Sysbus read-request tag.
package fetch_pkg;

  localparam logic [3:0]  SYSBUS_MEMORY  = 4'b0001;
  localparam logic [12:0] FETCH_READ_TAG = {1'b1, SYSBUS_MEMORY, 8'b0};

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_INIT       = 3'd0;
  localparam fetch_state_t ST_WAIT_SPACE = 3'd1;
  localparam fetch_state_t ST_REQ        = 3'd2;
  localparam fetch_state_t ST_RESP       = 3'd3;
  localparam fetch_state_t ST_DISCARD    = 3'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO of {pc, instr} entries: up to IPB pushes per cycle, one pop,
// synchronous flush and a free-entry count for request throttling.
module fetch_fifo #(
  parameter int INSTR_WIDTH = 32,
  parameter int IPB         = 2,
  parameter int FIFO_DEPTH  = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [IPB-1:0]             push_vld,
  input  logic [IPB*INSTR_WIDTH-1:0] push_instr,
  input  logic [IPB*64-1:0]          push_pc,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [63:0]                out_pc,
  output logic [CNT_W-1:0]           free_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       push_cnt;
  logic [PTR_W-1:0]       slot_idx [IPB];
  logic                   do_pop;
  logic [INSTR_WIDTH-1:0] mem_instr [FIFO_DEPTH];
  logic [63:0]            mem_pc    [FIFO_DEPTH];

  // Valid slots are packed densely: each lands after the valid slots below it.
  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < IPB; j++) begin
      slot_idx[j] = wr_ptr + PTR_W'(push_cnt);
      push_cnt    = push_cnt + CNT_W'(push_vld[j]);
    end
  end

  assign do_pop = pop && (count != '0) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + push_cnt - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int j = 0; j < IPB; j++) begin
        if (push_vld[j]) begin
          mem_instr[slot_idx[j]] <= push_instr[j*INSTR_WIDTH +: INSTR_WIDTH];
          mem_pc[slot_idx[j]]    <= push_pc[j*64 +: 64];
        end
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? mem_pc[rd_ptr] : '0;
  assign free_cnt  = CNT_W'(FIFO_DEPTH) - count;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch engine: line burst reads on the Sysbus, beat splitting into
// instruction words, buffering for decode, redirect and halt-on-zero handling.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int INSTR_WIDTH    = 32,
  parameter int BURST_BEATS    = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      instr_valid,
  output logic [INSTR_WIDTH-1:0]    instr,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
  output logic                      halt
);

  localparam int IPB         = BUS_DATA_WIDTH / INSTR_WIDTH;
  localparam int LINE_BYTES  = BURST_BEATS * BUS_DATA_WIDTH / 8;
  localparam int BEAT_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [63:0]       LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
  localparam logic [CNT_W-1:0]  RESERVE   = CNT_W'(BURST_BEATS * IPB);

  fetch_state_t      state;
  logic [63:0]       fetch_pc;
  logic [63:0]       skip_pc;
  logic [63:0]       req_addr;
  logic [BEAT_W-1:0] beat_cnt;
  logic              redir_pend;

  logic              flush;
  logic              beat_fire;
  logic              last_beat;
  logic              resp_take;
  logic              zero_seen;
  logic              zero_hit;
  logic [63:0]       beat_base;
  logic [IPB-1:0]    keep;
  logic [IPB-1:0]    push_vld;
  logic [IPB*64-1:0] push_pc;
  logic [CNT_W-1:0]  free_cnt;
  logic              unused_tag;

  // The tag is not needed to match responses: only one burst is ever in flight.
  assign unused_tag = ^bus_resptag;

  assign flush     = redirect_valid && (state != ST_INIT);
  assign beat_fire = bus_respcyc && ((state == ST_RESP) || (state == ST_DISCARD));
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign resp_take = (state == ST_RESP) && bus_respcyc && !redirect_valid;
  assign beat_base = req_addr + 64'(beat_cnt) * 64'(BEAT_BYTES);

  // Keep words at or above skip_pc; the first zero word ends the beat.
  always_comb begin
    logic [63:0] pc_k;
    keep      = '0;
    zero_seen = 1'b0;
    push_pc   = '0;
    for (int k = 0; k < IPB; k++) begin
      pc_k               = beat_base + 64'(k * INSTR_BYTES);
      push_pc[k*64 +: 64] = pc_k;
      if (!zero_seen && (pc_k >= skip_pc)) begin
        if (bus_resp[k*INSTR_WIDTH +: INSTR_WIDTH] == '0) zero_seen = 1'b1;
        else                                               keep[k]   = 1'b1;
      end
    end
  end

  assign push_vld = resp_take ? keep : '0;
  assign zero_hit = resp_take && zero_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      fetch_pc   <= '0;
      skip_pc    <= '0;
      req_addr   <= '0;
      beat_cnt   <= '0;
      redir_pend <= 1'b0;
      halt       <= 1'b0;
    end else begin
      if (flush) begin
        fetch_pc <= redirect_pc & LINE_MASK;
        skip_pc  <= redirect_pc;
        halt     <= 1'b0;
      end
      if (zero_hit) halt <= 1'b1;

      case (state)
        ST_INIT: begin
          fetch_pc <= entry;
          state    <= ST_WAIT_SPACE;
        end
        ST_WAIT_SPACE: begin
          if (!flush && !halt && (free_cnt >= RESERVE)) begin
            req_addr   <= fetch_pc & LINE_MASK;
            redir_pend <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) redir_pend <= 1'b1;
          if (bus_reqack) begin
            beat_cnt <= '0;
            state    <= (flush || redir_pend) ? ST_DISCARD : ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus_respcyc) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) begin
              if (!flush) fetch_pc <= req_addr + 64'(LINE_BYTES);
              state <= ST_WAIT_SPACE;
            end else if (flush || zero_seen) begin
              state <= ST_DISCARD;
            end
          end else if (flush) begin
            state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (bus_respcyc) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) state <= ST_WAIT_SPACE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus_reqcyc  = (state == ST_REQ);
  assign bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(req_addr) : '0;
  assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(FETCH_READ_TAG) : '0;
  assign bus_respack = beat_fire;

  fetch_fifo #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .IPB         (IPB),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_vld   (push_vld),
    .push_instr (bus_resp),
    .push_pc    (push_pc),
    .pop        (instr_ready),
    .out_valid  (instr_valid),
    .out_instr  (instr),
    .out_pc     (instr_pc),
    .free_cnt   (free_cnt)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized bus timing, decode
// backpressure and redirects, checked against a sequential-PC program model.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = 64'h1000;
  logic        bus_reqcyc;
  logic        bus_reqack = 1'b0;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc = 1'b0;
  logic        bus_respack;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        halt;

  fetch_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .bus_reqcyc     (bus_reqcyc),
    .bus_reqack     (bus_reqack),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_respcyc    (bus_respcyc),
    .bus_respack    (bus_respack),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Program image: word at pc is (pc/4 - 0x3FF), except one optional zero word.
  logic [63:0] zero_pc = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] mem_word(input logic [63:0] pc);
    if (pc == zero_pc) return 32'h0;
    return 32'(pc >> 2) - 32'h3FF;
  endfunction

  // Bus slave: one line burst per accepted request.
  bit          rand_bus = 1'b0;
  int          rphase = 0;
  int          rbeat = 0;
  int          req_cnt = 0;
  logic [63:0] raddr = '0;
  logic [63:0] last_req = '0;

  always @(negedge clk) begin
    if (!reset) begin
      rphase      = 0;
      rbeat       = 0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
    end else begin
      if (rphase == 0) begin
        bus_respcyc = 1'b0;
        if (bus_reqack) begin
          bus_reqack = 1'b0;
          rphase     = 1;
          rbeat      = 0;
        end else if (bus_reqcyc && (!rand_bus || $urandom_range(0, 2) == 0)) begin
          bus_reqack = 1'b1;
          raddr      = bus_req;
          last_req   = bus_req;
          req_cnt++;
        end
      end
      if (rphase == 1) begin
        if (bus_respcyc) rbeat++;
        if (rbeat == 8) begin
          rphase      = 0;
          bus_respcyc = 1'b0;
        end else begin
          bus_respcyc = !rand_bus || ($urandom_range(0, 3) != 0);
          bus_resp    = {mem_word(raddr + 64'(rbeat * 8) + 64'd4), mem_word(raddr + 64'(rbeat * 8))};
        end
      end
    end
  end

  // Decode side: drives ready/redirect and checks each pop against the model.
  int          cmode = 0;
  bit          rand_redir = 1'b0;
  int          redir_seq = 0;
  int          redir_done = 0;
  logic [63:0] redir_target = '0;
  bit          redir_ready = 1'b0;
  logic [63:0] exp_pc = '0;
  int          pop_cnt = 0;
  int          since_rst = 0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc         = entry;
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      prev_hold      = 1'b0;
      since_rst      = 0;
    end else begin
      bit force_rdy;
      since_rst++;
      force_rdy = 1'b0;
      if (prev_hold) begin
        check_val("hold_pc", instr_pc, prev_pc);
        check_val("hold_instr", 64'(instr), 64'(prev_instr));
      end
      redirect_valid = 1'b0;
      if (redir_seq != redir_done) begin
        redir_done     = redir_seq;
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        force_rdy      = redir_ready;
      end else if (rand_redir && since_rst > 4 && $urandom_range(0, 79) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'($urandom_range(32'h1000, 32'h7FFC)) & ~64'h3;
      end
      case (cmode)
        0:       instr_ready = 1'b0;
        1:       instr_ready = 1'($urandom_range(0, 1));
        default: instr_ready = 1'b1;
      endcase
      if (force_rdy) instr_ready = 1'b1;
      if (instr_valid && instr_ready && !redirect_valid) begin
        check_val("pop_pc", instr_pc, exp_pc);
        check_val("pop_instr", 64'(instr), 64'(mem_word(exp_pc)));
        check_val("pop_nonzero", 64'(instr == 32'h0), 64'd0);
        exp_pc = exp_pc + 64'd4;
        pop_cnt++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_hold  = instr_valid && !instr_ready && !redirect_valid;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
  end

  task automatic do_redirect(input logic [63:0] pc, input bit with_ready);
    @(posedge clk);
    redir_target = pc;
    redir_ready  = with_ready;
    redir_seq++;
    @(negedge clk);
  endtask

  task automatic wait_req(input int n, input int budget);
    int c = 0;
    while (req_cnt < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check_val("req_wait", 64'(req_cnt >= n), 64'd1);
  endtask

  task automatic wait_beat(input int b, input int budget);
    int c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (!(rphase == 1 && rbeat == b) && c < budget);
    check_val("beat_wait", 64'(rphase == 1 && rbeat == b), 64'd1);
  endtask

  initial begin
    int saved;
    // Reset values
    #3;
    check_val("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check_val("rst_req", bus_req, 64'd0);
    check_val("rst_reqtag", 64'(bus_reqtag), 64'd0);
    check_val("rst_respack", 64'(bus_respack), 64'd0);
    check_val("rst_valid", 64'(instr_valid), 64'd0);
    check_val("rst_instr", 64'(instr), 64'd0);
    check_val("rst_pc", instr_pc, 64'd0);
    check_val("rst_halt", 64'(halt), 64'd0);

    // First request two cycles after release, then a full burst with no pops
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_val("reqcyc_c1", 64'(bus_reqcyc), 64'd0);
    @(posedge clk); #1;
    check_val("reqcyc_c2", 64'(bus_reqcyc), 64'd1);
    check_val("req_addr0", bus_req, 64'h1000);
    check_val("req_tag0", 64'(bus_reqtag), 64'h1100);
    repeat (20) @(posedge clk);
    #1;
    check_val("full_valid", 64'(instr_valid), 64'd1);
    check_val("full_head_pc", instr_pc, 64'h1000);
    repeat (20) @(posedge clk);
    check_val("no_second_req", 64'(req_cnt), 64'd1);

    // Drain: second request only after all 16 pops
    cmode = 2;
    wait_req(2, 100);
    check_val("pops_before_req2", 64'(pop_cnt), 64'd16);
    check_val("req_addr1", last_req, 64'h1040);

    // Redirect in the middle of a burst
    cmode = 0;
    wait_beat(5, 100);
    saved = req_cnt;
    do_redirect(64'h2008, 1'b0);
    @(negedge clk);
    check_val("redir_flush", 64'(instr_valid), 64'd0);
    cmode = 2;
    wait_req(saved + 1, 100);
    check_val("redir_req_addr", last_req, 64'h2000);
    repeat (10) @(posedge clk);

    // Zero word in beat 3 halts fetching
    zero_pc = 64'h101C;
    do_redirect(64'h1000, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check_val("halt_set", 64'(halt), 64'd1);
    check_val("halt_stream_end", exp_pc, 64'h101C);
    saved = req_cnt;
    repeat (30) @(posedge clk);
    check_val("halt_no_req", 64'(req_cnt), 64'(saved));
    check_val("halt_empty", 64'(instr_valid), 64'd0);

    // Redirect coinciding with a pop
    zero_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    cmode = 0;
    do_redirect(64'h4000, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check_val("halt_cleared", 64'(halt), 64'd0);
    check_val("pre_pop_valid", 64'(instr_valid), 64'd1);
    do_redirect(64'h5000, 1'b1);
    @(negedge clk);
    check_val("pop_flush_empty", 64'(instr_valid), 64'd0);
    cmode = 2;
    repeat (40) @(posedge clk);

    // Reset mid-burst, restart from a new entry
    cmode = 0;
    entry = 64'h6000;
    wait_beat(3, 100);
    #2 reset = 1'b0;
    #1;
    check_val("mid_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check_val("mid_rst_respack", 64'(bus_respack), 64'd0);
    check_val("mid_rst_valid", 64'(instr_valid), 64'd0);
    check_val("mid_rst_instr", 64'(instr), 64'd0);
    check_val("mid_rst_pc", instr_pc, 64'd0);
    check_val("mid_rst_halt", 64'(halt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    saved = req_cnt;
    wait_req(saved + 1, 50);
    check_val("refetch_addr", last_req, 64'h6000);
    cmode = 2;
    repeat (30) @(posedge clk);

    // Randomized bus timing, backpressure and redirects
    zero_pc    = 64'h6100;
    rand_bus   = 1'b1;
    cmode      = 1;
    rand_redir = 1'b1;
    saved      = pop_cnt;
    repeat (5000) @(posedge clk);
    rand_redir = 1'b0;
    check_val("rand_progress", 64'(pop_cnt > saved + 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
